m6502_bus_ctrl: RTL
===================

# m6502_bus_ctrl

Memory/I-O bus controller directly downstream of the 6502 CPU core's `addr`/`rd_data`/`wr_data`/`wr_en`/`rd_req`/`ready` bus. It decodes each CPU access to synchronous SRAM or to the memory-mapped I/O window, inserts wait states by dropping `ready`, and returns read data. A secondary DMA read master (video fetch) gets the SRAM whenever the CPU is not using it.

## Interface
- `IO_BASE`, 16'hD000: I/O window base; hit when `(addr & IO_MASK) == IO_BASE`.
- `IO_MASK`, 16'hF000: I/O window decode mask.
- `MEM_WAIT`, 0: extra SRAM read wait cycles (0-7).
- `IO_TIMEOUT`, 15: cycles without `io_ack` before an I/O access is aborted (1-255).

Clock and reset: reset_n, synchronous, active-low; clock clk.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous active-low reset.
- `cpu_addr`  in  16  CPU address.
- `cpu_rd_req`  in  1  one-cycle read request pulse.
- `cpu_wr_en`  in  1  one-cycle write pulse.
- `cpu_wr_data`  in  8  write data, valid with `cpu_wr_en`.
- `cpu_rd_data`  out  8  registered read data, valid while `cpu_ready`=1 after a read.
- `cpu_ready`  out  1  0 = access in progress.
- `mem_addr`  out  16  SRAM address.
- `mem_en`  out  1  SRAM access strobe.
- `mem_we`  out  1  SRAM write strobe (with `mem_en`).
- `mem_wdata`  out  8  SRAM write data.
- `mem_rdata`  in  8  SRAM read data, valid the cycle after `mem_en`.
- `io_addr`  out  16  I/O address.
- `io_rd`, `io_wr`  out  1  I/O strobes, held until `io_ack` or timeout.
- `io_wdata`  out  8  I/O write data.
- `io_rdata`  in  8  I/O read data, valid with `io_ack`.
- `io_ack`  in  1  I/O completion.
- `dma_req`  in  1  level request for one SRAM byte.
- `dma_addr`  in  16  DMA address, stable while `dma_req`.
- `dma_gnt`  out  1  one-cycle pulse: request accepted.
- `dma_valid`  out  1  one-cycle pulse: `dma_rdata` valid.
- `dma_rdata`  out  8  DMA read data.

## Operation
- States: IDLE, MEM_RD, MEM_CAP, IO_WAIT, DMA_RD, DMA_CAP.
- CPU pulse is latched into a one-entry pending register (addr, data, rd/wr, io-hit) on any edge where `cpu_rd_req` or `cpu_wr_en` is 1; both at once → read ignored, write taken.
- IDLE priority: pending CPU > DMA. DMA is never granted while a CPU access is pending.
- CPU SRAM read: IDLE → MEM_RD (`mem_en`=1, `MEM_WAIT` extra cycles holding addr) → MEM_CAP (capture `mem_rdata` into `cpu_rd_data`, `cpu_ready`←1) → IDLE.
- CPU SRAM write in IDLE: `mem_en`=`mem_we`=1 for one cycle, `cpu_ready` stays 1. If not accepted immediately (DMA in flight), `cpu_ready`←0 until the write issues.
- CPU I/O read/write: IDLE → IO_WAIT, strobe held; on `io_ack` capture `io_rdata` (reads), `cpu_ready`←1, → IDLE. On timeout: read returns 8'hFF, write dropped, `cpu_ready`←1.
- DMA: IDLE with `dma_req` → `dma_gnt` pulse, DMA_RD (`mem_en`=1 at `dma_addr`) → DMA_CAP (`dma_valid`, `dma_rdata`) → IDLE. DMA always addresses SRAM, even in the I/O window.
- `cpu_rd_data` holds last read value until next read completes.

## Timing
- Reset values: `cpu_ready`=1, `cpu_rd_data`=0, all strobes/pulses 0, addresses/data 0, state IDLE, pending empty, timeout counter 0.
- `cpu_ready`←0 at the same edge that samples a CPU read or any access that cannot complete immediately; low from the following cycle.
- SRAM read, idle bus: `cpu_rd_req` high cycle 0; `cpu_ready` low cycles 1..2+`MEM_WAIT`; high with data cycle 3+`MEM_WAIT`.
- CPU read arriving while DMA in DMA_RD/DMA_CAP: latched, served after DMA_CAP; adds ≤2 cycles.
- DMA back-to-back: one byte per 3 cycles (IDLE, DMA_RD, DMA_CAP).
- Timeout counter: loaded at IO_WAIT entry, abort when it reaches `IO_TIMEOUT`; `io_ack` on the expiry cycle wins (data accepted).
- Reset mid-access: all state abandoned within one edge; pending and strobes cleared; no completion reported.

## Structure
- Package `m6502_bus_pkg`: state enum, IO_BASE/IO_MASK defaults, bus constant 8'hFF for I/O timeout data.
- Single module; the pending-request latch may be the sub-module `m6502_bus_pend`. No other hierarchy.

## Test plan
- Reset, then read 16'h1234 (SRAM=8'hA5), `MEM_WAIT`=0 → `cpu_ready` low 2 cycles, `cpu_rd_data`=8'hA5 in cycle 3.
- Write 8'h5A to 16'h0200, then read it → `mem_we` one cycle, `cpu_ready` never drops for write, read returns 8'h5A.
- Read 16'hD010, `io_ack` after 4 cycles with 8'h3C → `io_rd` held 4 cycles, `cpu_rd_data`=8'h3C, `cpu_ready`=1 next cycle.
- Read 16'hD000 with no `io_ack`, `IO_TIMEOUT`=15 → `cpu_rd_data`=8'hFF after 15 cycles.
- `dma_req` at 16'h4000 (8'h77), CPU read 16'h0010 one cycle after `dma_gnt` → `dma_valid` with 8'h77 first, CPU read completes after DMA_CAP with correct data.
- Assert `reset_n`=0 during IO_WAIT → next cycle `io_rd`=0, `cpu_ready`=1, state IDLE.

Source files
------------

// File: rtl/m6502_bus_ctrl_pkg.sv
// Shared types and constants for the 6502 memory/I-O bus controller.
// The controller's state, its registered outputs and the latched CPU request.
package m6502_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MEM_RD,
      MEM_CAP,
      IO_WAIT,
      DMA_RD,
      DMA_CAP
   } state_t;

   localparam logic [15:0] IO_BASE_DEFAULT = 16'hD000;
   localparam logic [15:0] IO_MASK_DEFAULT = 16'hF000;
   localparam logic [7:0]  IO_TIMEOUT_DATA = 8'hFF;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        wr;
      logic        io;
   } cpu_req_t;

   // Every registered output of the controller, plus its two counters.
   typedef struct packed {
      logic        cpu_ready;
      logic [7:0]  cpu_rd_data;
      logic [15:0] mem_addr;
      logic        mem_en;
      logic        mem_we;
      logic [7:0]  mem_wdata;
      logic [15:0] io_addr;
      logic        io_rd;
      logic        io_wr;
      logic [7:0]  io_wdata;
      logic        dma_gnt;
      logic        dma_valid;
      logic [7:0]  dma_rdata;
      logic [2:0]  wait_cnt;
      logic [7:0]  io_cnt;
   } ctrl_regs_t;

   localparam ctrl_regs_t CTRL_RESET = '{cpu_ready: 1'b1, default: '0};

   function automatic logic io_hit(input logic [15:0] addr,
                                   input logic [15:0] base,
                                   input logic [15:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/m6502_bus_ctrl_if.sv
// Bus bundle between the controller and the CPU, SRAM, I/O window and DMA master.
// The controller takes the master modport; the surrounding system takes slave.
interface m6502_bus_ctrl_if;
   logic [15:0] cpu_addr;
   logic        cpu_rd_req;
   logic        cpu_wr_en;
   logic [7:0]  cpu_wr_data;
   logic [7:0]  cpu_rd_data;
   logic        cpu_ready;

   logic [15:0] mem_addr;
   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [15:0] io_addr;
   logic        io_rd;
   logic        io_wr;
   logic [7:0]  io_wdata;
   logic [7:0]  io_rdata;
   logic        io_ack;

   logic        dma_req;
   logic [15:0] dma_addr;
   logic        dma_gnt;
   logic        dma_valid;
   logic [7:0]  dma_rdata;

   modport master (
      input  cpu_addr, cpu_rd_req, cpu_wr_en, cpu_wr_data, mem_rdata,
             io_rdata, io_ack, dma_req, dma_addr,
      output cpu_rd_data, cpu_ready, mem_addr, mem_en, mem_we, mem_wdata,
             io_addr, io_rd, io_wr, io_wdata, dma_gnt, dma_valid, dma_rdata
   );

   modport slave (
      output cpu_addr, cpu_rd_req, cpu_wr_en, cpu_wr_data, mem_rdata,
             io_rdata, io_ack, dma_req, dma_addr,
      input  cpu_rd_data, cpu_ready, mem_addr, mem_en, mem_we, mem_wdata,
             io_addr, io_rd, io_wr, io_wdata, dma_gnt, dma_valid, dma_rdata
   );
endinterface

// File: rtl/m6502_bus_ctrl_pend.sv
// One-entry CPU request latch. The incoming pulse is bypassed straight to the
// controller so an idle bus can start the access on the very edge that samples it.
module m6502_bus_pend
   import m6502_bus_pkg::*;
#(
   parameter logic [15:0] IO_BASE = IO_BASE_DEFAULT,
   parameter logic [15:0] IO_MASK = IO_MASK_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rd_req,
   input  logic        wr_en,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic        take,
   output logic        req_valid,
   output cpu_req_t    req
);

   logic     pulse;
   logic     valid;
   cpu_req_t stored;
   cpu_req_t incoming;

   // A simultaneous read and write is treated as the write alone.
   assign pulse     = rd_req | wr_en;
   assign incoming  = '{addr: addr, wdata: wdata, wr: wr_en,
                        io: io_hit(addr, IO_BASE, IO_MASK)};
   assign req_valid = valid | pulse;
   assign req       = valid ? stored : incoming;

   // NOTE: reset is synchronous, so it sits inside the clocked branch rather
   // than in the sensitivity list; the payload is cleared too, not just valid.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid  <= 1'b0;
         stored <= '0;
      end else begin
         // A pulse consumed through the bypass never lands in the latch.
         if (pulse && (valid || !take)) stored <= incoming;
         valid <= pulse ? (valid || !take) : (valid && !take);
      end
   end

endmodule

// File: rtl/m6502_bus_ctrl.sv
// Decodes CPU accesses to SRAM or the I/O window, stalls the CPU via cpu_ready,
// and lends idle SRAM cycles to a read-only DMA master.
module m6502_bus_ctrl
   import m6502_bus_pkg::*;
#(
   parameter logic [15:0] IO_BASE    = IO_BASE_DEFAULT,
   parameter logic [15:0] IO_MASK    = IO_MASK_DEFAULT,
   parameter int          MEM_WAIT   = 0,
   parameter int          IO_TIMEOUT = 15
) (
   input logic              clk,
   input logic              reset_n,
   m6502_bus_ctrl_if.master bus
);

   state_t     state, state_n;
   ctrl_regs_t r, r_n;
   cpu_req_t   req;
   logic       req_valid;
   logic       take;
   logic       wr_now;
   logic       pulse;

   assign pulse = bus.cpu_rd_req | bus.cpu_wr_en;

   m6502_bus_pend #(.IO_BASE(IO_BASE), .IO_MASK(IO_MASK)) u_pend (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_req    (bus.cpu_rd_req),
      .wr_en     (bus.cpu_wr_en),
      .addr      (bus.cpu_addr),
      .wdata     (bus.cpu_wr_data),
      .take      (take),
      .req_valid (req_valid),
      .req       (req)
   );

   // NOTE: sequential state uses non-blocking assignments only; all decisions
   // are made in the combinational block below.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         r     <= CTRL_RESET;
      end else begin
         state <= state_n;
         r     <= r_n;
      end
   end

   // NOTE: every variable gets a default before the case so no path infers a latch.
   always_comb begin
      state_n     = state;
      r_n         = r;
      take        = 1'b0;
      wr_now      = 1'b0;
      r_n.mem_en    = 1'b0;
      r_n.mem_we    = 1'b0;
      r_n.dma_gnt   = 1'b0;
      r_n.dma_valid = 1'b0;

      case (state)
         IDLE: begin
            if (req_valid) begin
               take = 1'b1;
               if (req.io) begin
                  state_n       = IO_WAIT;
                  r_n.io_addr   = req.addr;
                  r_n.io_wdata  = req.wdata;
                  r_n.io_rd     = !req.wr;
                  r_n.io_wr     = req.wr;
                  r_n.io_cnt    = '0;
                  r_n.cpu_ready = 1'b0;
               end else if (req.wr) begin
                  wr_now        = 1'b1;
                  r_n.mem_en    = 1'b1;
                  r_n.mem_we    = 1'b1;
                  r_n.mem_addr  = req.addr;
                  r_n.mem_wdata = req.wdata;
                  r_n.cpu_ready = 1'b1;
               end else begin
                  state_n       = MEM_RD;
                  r_n.mem_en    = 1'b1;
                  r_n.mem_addr  = req.addr;
                  r_n.wait_cnt  = 3'(MEM_WAIT);
                  r_n.cpu_ready = 1'b0;
               end
            end else if (bus.dma_req) begin
               state_n      = DMA_RD;
               r_n.dma_gnt  = 1'b1;
               r_n.mem_en   = 1'b1;
               r_n.mem_addr = bus.dma_addr;
               r_n.wait_cnt = 3'(MEM_WAIT);
            end
         end
         MEM_RD, DMA_RD: begin
            // Keep the strobe and address up through the extra wait cycles.
            if (r.wait_cnt == 3'd0) begin
               state_n = (state == MEM_RD) ? MEM_CAP : DMA_CAP;
            end else begin
               r_n.wait_cnt = r.wait_cnt - 3'd1;
               r_n.mem_en   = 1'b1;
            end
         end
         MEM_CAP: begin
            state_n         = IDLE;
            r_n.cpu_rd_data = bus.mem_rdata;
            r_n.cpu_ready   = 1'b1;
         end
         DMA_CAP: begin
            state_n       = IDLE;
            r_n.dma_rdata = bus.mem_rdata;
            r_n.dma_valid = 1'b1;
         end
         IO_WAIT: begin
            // An ack on the expiry cycle still delivers real data.
            if (bus.io_ack || (r.io_cnt + 8'd1 == 8'(IO_TIMEOUT))) begin
               state_n       = IDLE;
               r_n.io_rd     = 1'b0;
               r_n.io_wr     = 1'b0;
               r_n.cpu_ready = 1'b1;
               if (r.io_rd) r_n.cpu_rd_data = bus.io_ack ? bus.io_rdata : IO_TIMEOUT_DATA;
            end else begin
               r_n.io_cnt = r.io_cnt + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      // Any CPU access that is not an SRAM write issued right now stalls the CPU.
      if (pulse && !wr_now) r_n.cpu_ready = 1'b0;
   end

   assign bus.cpu_ready   = r.cpu_ready;
   assign bus.cpu_rd_data = r.cpu_rd_data;
   assign bus.mem_addr    = r.mem_addr;
   assign bus.mem_en      = r.mem_en;
   assign bus.mem_we      = r.mem_we;
   assign bus.mem_wdata   = r.mem_wdata;
   assign bus.io_addr     = r.io_addr;
   assign bus.io_rd       = r.io_rd;
   assign bus.io_wr       = r.io_wr;
   assign bus.io_wdata    = r.io_wdata;
   assign bus.dma_gnt     = r.dma_gnt;
   assign bus.dma_valid   = r.dma_valid;
   assign bus.dma_rdata   = r.dma_rdata;

endmodule
